// File: rtl/updown_counter.sv
// Parametrised up/down counter with modulus, prescaler, load/clear,
// wrap or saturate limits, terminal-count pulse and sticky overflow flag.
module updown_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MOD      = 2 ** WIDTH,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MOD - 1);
  localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);

  if (WIDTH < 1 || MOD < 2 || MOD > 2 ** WIDTH || PRESCALE < 1) begin : g_bad_param
    $error("updown_counter: illegal WIDTH/MOD/PRESCALE combination");
  end

  logic [PW-1:0]    pcnt;
  logic             step;
  logic             at_limit;
  logic             limit;
  logic [WIDTH-1:0] q_step;

  // Step decode and next count; the limit checks keep q inside 0..MOD-1.
  always_comb begin
    step     = en && (pcnt == PMAX);
    at_limit = up ? (q == QMAX) : (q == '0);
    limit    = step && !clr && !load && at_limit;
    q_step   = q;
    if (up) begin
      q_step = at_limit ? (sat ? q : '0) : q + WIDTH'(1);
    end else begin
      q_step = at_limit ? (sat ? q : QMAX) : q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      pcnt <= '0;
      tc   <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (clr) begin
        q    <= '0;
        pcnt <= '0;
      end else if (load) begin
        q    <= (load_val > QMAX) ? QMAX : load_val;
        pcnt <= '0;
      end else if (en) begin
        pcnt <= step ? '0 : pcnt + PW'(1);
        if (step) q <= q_step;
      end
      tc <= limit;
      // A limit event on the same edge as ovf_clr keeps the flag set.
      if (limit) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: directed scenarios plus randomized run against
// an arithmetic reference model, on three parameter sets.
module tb_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       sat;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic       ovf_clr;

  logic [3:0] qa, qb;
  logic [7:0] qc;
  logic       tca, tcb, tcc, ovfa, ovfb, ovfc;

  int vectors;
  int miscompares;

  updown_counter #(.WIDTH(4), .MOD(10), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .ovf_clr(ovf_clr), .q(qa), .tc(tca), .ovf(ovfa));

  updown_counter #(.WIDTH(4), .MOD(10), .PRESCALE(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .ovf_clr(ovf_clr), .q(qb), .tc(tcb), .ovf(ovfb));

  updown_counter dut_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .q(qc), .tc(tcc), .ovf(ovfc));

  logic [7:0] oq[3];
  logic       ot[3];
  logic       oo[3];
  assign oq[0] = {4'b0, qa};
  assign oq[1] = {4'b0, qb};
  assign oq[2] = qc;
  assign ot[0] = tca;
  assign ot[1] = tcb;
  assign ot[2] = tcc;
  assign oo[0] = ovfa;
  assign oo[1] = ovfb;
  assign oo[2] = ovfc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain integer arithmetic per parameter set.
  int mw[3]  = '{4, 4, 8};
  int mm[3]  = '{10, 10, 256};
  int mpr[3] = '{1, 3, 1};
  int mq[3];
  int mp[3];
  bit mtc[3];
  bit movf[3];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      int lv;
      bit lim;
      if (rst) begin
        mq[i] = 0; mp[i] = 0; mtc[i] = 0; movf[i] = 0;
      end else begin
        lim = 0;
        lv  = int'(load_val) % (1 << mw[i]);
        if (clr) begin
          mq[i] = 0; mp[i] = 0;
        end else if (load) begin
          mq[i] = (lv > mm[i] - 1) ? mm[i] - 1 : lv;
          mp[i] = 0;
        end else if (en) begin
          mp[i] = mp[i] + 1;
          if (mp[i] == mpr[i]) begin
            mp[i] = 0;
            if (up) begin
              if (mq[i] == mm[i] - 1) begin lim = 1; if (!sat) mq[i] = 0; end
              else mq[i] = mq[i] + 1;
            end else begin
              if (mq[i] == 0) begin lim = 1; if (!sat) mq[i] = mm[i] - 1; end
              else mq[i] = mq[i] - 1;
            end
          end
        end
        mtc[i] = lim;
        if (lim) movf[i] = 1;
        else if (ovf_clr) movf[i] = 0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up = 1'b1; sat = 1'b0; clr = 1'b0; load = 1'b0;
    load_val = 8'd0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (oq[i] !== 8'd0 || ot[i] !== 1'b0 || oo[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset dut%0d q=%0d tc=%b ovf=%b expected 0/0/0", i, oq[i], ot[i], oo[i]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    rst = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if (qa !== 4'd6) begin miscompares++; $display("FAIL count_to_6 q=%0d expected 6", qa); end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (qa !== 4'd0 || tca !== 1'b0 || ovfa !== 1'b0 || qb !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset qa=%0d tc=%b ovf=%b qb=%0d expected 0/0/0/0", qa, tca, ovfa, qb);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (qa !== 4'd1) begin miscompares++; $display("FAIL first_step_after_reset q=%0d expected 1", qa); end
  endtask

  task automatic test_wrap();
    en = 1'b0; load = 1'b1; load_val = 8'd9;
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
    @(negedge clk);
    vectors++;
    if (qa !== 4'd0 || tca !== 1'b1 || ovfa !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_up q=%0d tc=%b ovf=%b expected 0/1/1", qa, tca, ovfa);
    end
    en = 1'b0;
    @(negedge clk);
    vectors++;
    if (tca !== 1'b0 || qa !== 4'd0) begin
      miscompares++;
      $display("FAIL tc_single_cycle q=%0d tc=%b expected 0/0", qa, tca);
    end
    en = 1'b1; up = 1'b0;
    @(negedge clk);
    vectors++;
    if (qa !== 4'd9 || tca !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_down q=%0d tc=%b expected 9/1", qa, tca);
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    load = 1'b1; load_val = 8'd9;
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (qa !== 4'd9 || tca !== 1'b1 || ovfa !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_hold step%0d q=%0d tc=%b ovf=%b expected 9/1/1", k, qa, tca, ovfa);
      end
    end
    up = 1'b0;
    @(negedge clk);
    vectors++;
    if (qa !== 4'd8 || tca !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_leave q=%0d tc=%b expected 8/0", qa, tca);
    end
    en = 1'b0; sat = 1'b0;
  endtask

  task automatic test_prescale();
    en = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (qb !== 4'd0) begin miscompares++; $display("FAIL presc_edge2 q=%0d expected 0", qb); end
    @(negedge clk);
    vectors++;
    if (qb !== 4'd1) begin miscompares++; $display("FAIL presc_edge3 q=%0d expected 1", qb); end
    repeat (3) @(negedge clk);
    vectors++;
    if (qb !== 4'd2) begin miscompares++; $display("FAIL presc_edge6 q=%0d expected 2", qb); end
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    vectors++;
    if (qb !== 4'd2) begin miscompares++; $display("FAIL presc_frozen q=%0d expected 2", qb); end
    @(negedge clk);
    vectors++;
    if (qb !== 4'd3) begin miscompares++; $display("FAIL presc_delayed q=%0d expected 3", qb); end
    en = 1'b0;
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_val = 8'd12;
    @(negedge clk);
    vectors++;
    if (qa !== 4'd9 || qc !== 8'd12) begin
      miscompares++;
      $display("FAIL load_clamp qa=%0d qc=%0d expected 9/12", qa, qc);
    end
    clr = 1'b1;
    @(negedge clk);
    vectors++;
    if (qa !== 4'd0) begin miscompares++; $display("FAIL clr_over_load q=%0d expected 0", qa); end
    clr = 1'b0; load_val = 8'd5; en = 1'b1; up = 1'b1;
    @(negedge clk);
    vectors++;
    if (qa !== 4'd5 || qb !== 4'd5 || tca !== 1'b0) begin
      miscompares++;
      $display("FAIL load_over_step qa=%0d qb=%0d tc=%b expected 5/5/0", qa, qb, tca);
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_ovf();
    clr = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    vectors++;
    if (ovfa !== 1'b0 || qa !== 4'd0) begin
      miscompares++;
      $display("FAIL ovf_clr q=%0d ovf=%b expected 0/0", qa, ovfa);
    end
    clr = 1'b0; ovf_clr = 1'b0; en = 1'b1; up = 1'b0; sat = 1'b0;
    @(negedge clk);
    vectors++;
    if (qa !== 4'd9 || ovfa !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow_sets_ovf q=%0d ovf=%b expected 9/1", qa, ovfa);
    end
    en = 1'b0; ovf_clr = 1'b1;
    @(negedge clk);
    vectors++;
    if (ovfa !== 1'b0) begin miscompares++; $display("FAIL ovf_clear ovf=%b expected 0", ovfa); end
    ovf_clr = 1'b0; load = 1'b1; load_val = 8'd9;
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    vectors++;
    if (ovfa !== 1'b1 || qa !== 4'd0) begin
      miscompares++;
      $display("FAIL set_beats_clear q=%0d ovf=%b expected 0/1", qa, ovfa);
    end
    en = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (oq[i] !== 8'(mq[i]) || ot[i] !== mtc[i] || oo[i] !== movf[i]) begin
          miscompares++;
          $display("FAIL random cyc%0d dut%0d q=%0d tc=%b ovf=%b expected %0d/%b/%b",
                   n, i, oq[i], ot[i], oo[i], mq[i], mtc[i], movf[i]);
        end
      end
      rst      = rst ? 1'b0 : ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) up = ~up;
      if ($urandom_range(0, 63) == 0) sat = ~sat;
      clr      = ($urandom_range(0, 63) == 0);
      load     = ($urandom_range(0, 31) == 0);
      load_val = 8'($urandom);
      ovf_clr  = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_reset_mid_count();
    test_wrap();
    test_saturate();
    test_prescale();
    test_load_priority();
    test_ovf();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down counter for general-purpose event counting, timebases and sequencing. It supports programmable modulus, a clock-enable prescaler, parallel load, synchronous clear, wrap or saturate behaviour, a terminal-count pulse and a sticky overflow flag. It sits beside the basic 3-bit up-counter and replaces it wherever width, direction, modulus or status reporting is needed.

## Interface
- WIDTH, 8: counter width in bits; must be at least 1.
- MOD, 2**WIDTH: count range is 0..MOD-1; must satisfy 2 ≤ MOD ≤ 2**WIDTH.
- PRESCALE, 1: number of enabled clocks per count step; must be at least 1.

- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; gates the prescaler and stepping.
- up  in  1  direction: 1 counts up, 0 counts down.
- sat  in  1  mode: 1 saturates at the limits, 0 wraps modulo MOD.
- clr  in  1  synchronous clear of q and the prescaler.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- ovf_clr  in  1  clears the sticky ovf flag.
- q  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse (registered).
- ovf  out  1  sticky overflow/underflow flag (registered).

## Operation
- Reset (async, any time, including mid-prescale): q=0, tc=0, ovf=0, prescale counter=0. Outputs stay at these values while rst is high.
- Per-edge priority: rst > clr > load > step.
- clr: q←0 and prescale counter←0. Also tc←0. ovf is not affected.
- load: q←load_val if load_val < MOD, otherwise q←MOD-1 (clamp). Prescale counter←0 and tc←0. ovf is not affected.
- Prescaler: a prescale counter, 0..PRESCALE-1, advances only on edges with en=1. A step occurs on the edge where en=1 and the prescale counter equals PRESCALE-1; the counter then returns to 0. With PRESCALE=1, every enabled edge is a step. en=0 freezes the prescale counter.
- Step, up=1: if q<MOD-1 then q←q+1. At q=MOD-1, wrap mode sets q←0 and saturate mode holds q at MOD-1. Both cases count as a limit event.
- Step, up=0: if q>0 then q←q-1. At q=0, wrap mode sets q←MOD-1 and saturate mode holds q at 0. Both cases count as a limit event.
- tc: is 1 for exactly one cycle after each edge that produced a limit event, and 0 otherwise. It reasserts on every consecutive limit event, including repeated saturated steps.
- ovf: is set on any limit event. ovf_clr clears it on the next edge. If a set and an ovf_clr occur on the same edge, the set wins (ovf=1).
- up and sat are sampled only on step edges and may change freely between steps.
- All arithmetic is unsigned WIDTH-bit. No intermediate value may exceed MOD-1, so no implicit 2**WIDTH wrap can occur when MOD < 2**WIDTH.

## Timing
- Latency: q, tc and ovf all update on the same rising edge that performs the clr, load or step. There is no combinational path from inputs to outputs.
- First step after reset, clr or load with en held high: PRESCALE edges later.
- clr or load together with en=1 on the same edge: the clr or load takes effect, no step occurs, and the prescale counter restarts at 0.
- Deassertion of rst is synchronous to clk: the first possible step is the first rising edge after rst falls.
- Steady counting at PRESCALE=P gives one step every P clocks. A wrap-mode full cycle takes MOD×P clocks, with one tc pulse per cycle.

## Test plan
- Reset mid-count (WIDTH=4, MOD=10, P=1): count to 6, pulse rst between edges → q=0, tc=0, ovf=0 immediately; the next enabled edge gives q=1.
- Wrap up/down (MOD=10, P=1, sat=0): from q=9 with up=1 → q=0, tc=1 for one cycle, ovf=1. Switch to up=0 at q=0 → q=9 with another tc pulse.
- Saturate (MOD=10, sat=1): at q=9, apply up=1 for 3 steps → q stays 9, tc high on 3 consecutive cycles, ovf=1. Then up=0 → q=8, tc=0.
- Prescale (P=3, MOD=10): hold en=1 from q=0 → q=1 after 3 edges, q=2 after 6. Drop en for 2 edges mid-count → the step is delayed by exactly 2 edges.
- Load and priority: load_val=12 with MOD=10 → q=9. Assert clr and load together → q=0. Assert load with en=1 on a step edge → q=load_val and no increment.
- ovf handling: create a limit event, then assert ovf_clr → ovf=0. Assert ovf_clr on the same edge as a wrap → ovf=1.
